// File: rtl/param_counter.sv
// param_counter: parametrised up/down modulo-MODULUS counter with enable,
// synchronous clear, clamped parallel load, wrap/saturate boundary handling,
// an input prescaler, a one-cycle terminal-count pulse and a sticky overflow
// flag. The default parameters give a plain 4-bit mod-16 up-counter.
module param_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // Prescaler phase needs at least one bit even when PRESCALE is 1.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);

    // Reject parameter sets that would give an empty or unrepresentable range.
    generate
        if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH)) || (PRESCALE < 1)) begin : g_bad_params
            $error("param_counter: illegal parameters (need 2 <= MODULUS <= 2**WIDTH, PRESCALE >= 1)");
        end
    endgenerate

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt_s;
    logic [PS_W-1:0]  ps_r;
    logic [PS_W-1:0]  ps_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             boundary_s;

    // A step is a boundary event when it would leave the 0..MODULUS-1 range.
    always_comb begin
        boundary_s = 1'b0;
        if (dir) begin
            boundary_s = (out_r == MAX_V);
        end else begin
            boundary_s = (out_r == {WIDTH{1'b0}});
        end
    end

    // Next-state selection with priority clear > load > step > hold.
    always_comb begin
        out_nxt_s = out_r;
        ps_nxt_s  = ps_r;
        tc_nxt_s  = 1'b0;
        ovf_nxt_s = ovf_r;
        if (clr) begin
            out_nxt_s = {WIDTH{1'b0}};
            ps_nxt_s  = {PS_W{1'b0}};
            ovf_nxt_s = 1'b0;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the count range.
            if (load_val > MAX_V) begin
                out_nxt_s = MAX_V;
            end else begin
                out_nxt_s = load_val;
            end
            ps_nxt_s = {PS_W{1'b0}};
        end else if (en) begin
            if (ps_r == PS_LAST) begin
                ps_nxt_s = {PS_W{1'b0}};
                if (boundary_s) begin
                    // A held saturating step is still a boundary event.
                    tc_nxt_s  = 1'b1;
                    ovf_nxt_s = 1'b1;
                    if (sat) begin
                        out_nxt_s = out_r;
                    end else if (dir) begin
                        out_nxt_s = {WIDTH{1'b0}};
                    end else begin
                        out_nxt_s = MAX_V;
                    end
                end else if (dir) begin
                    out_nxt_s = out_r + WIDTH'(1);
                end else begin
                    out_nxt_s = out_r - WIDTH'(1);
                end
            end else begin
                ps_nxt_s = ps_r + PS_W'(1);
            end
        end else begin
            out_nxt_s = out_r;
            ps_nxt_s  = ps_r;
        end
    end

    // State registers; reset discards all count and prescaler progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= {WIDTH{1'b0}};
            ps_r  <= {PS_W{1'b0}};
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            out_r <= out_nxt_s;
            ps_r  <= ps_nxt_s;
            tc_r  <= tc_nxt_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    assign out = out_r;
    assign tc  = tc_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: four instances with different parameter
// sets share one stimulus bus; each vector names the instance it checks.
module tb_param_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       dir;
    logic       sat;
    logic [3:0] o   [4];
    logic       tcs [4];
    logic       ovfs[4];

    int errors;
    int checks;

    // 0: defaults, 1: MODULUS=10, 2: PRESCALE=3, 3: MODULUS=7 PRESCALE=3
    param_counter u_def (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .sat(sat), .out(o[0]), .tc(tcs[0]), .ovf(ovfs[0]));
    param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (.clk(clk), .rst_n(rst_n),
        .en(en), .clr(clr), .load(load), .load_val(load_val), .dir(dir), .sat(sat),
        .out(o[1]), .tc(tcs[1]), .ovf(ovfs[1]));
    param_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_p3 (.clk(clk), .rst_n(rst_n),
        .en(en), .clr(clr), .load(load), .load_val(load_val), .dir(dir), .sat(sat),
        .out(o[2]), .tc(tcs[2]), .ovf(ovfs[2]));
    param_counter #(.WIDTH(4), .MODULUS(7), .PRESCALE(3)) u_m7p3 (.clk(clk), .rst_n(rst_n),
        .en(en), .clr(clr), .load(load), .load_val(load_val), .dir(dir), .sat(sat),
        .out(o[3]), .tc(tcs[3]), .ovf(ovfs[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        bit         rst;
        bit         clr;
        bit         load;
        logic [3:0] lv;
        bit         dir;
        bit         sat;
        bit         en;
        logic [3:0] eo;
        bit         etc;
        bit         eovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int d, bit r, bit c, bit l, int lv, bit di, bit s, bit e,
                                int eo, bit et, bit ev);
        vec_t v;
        v.dut = d; v.rst = r; v.clr = c; v.load = l; v.lv = 4'(lv);
        v.dir = di; v.sat = s; v.en = e; v.eo = 4'(eo); v.etc = et; v.eovf = ev;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_dut(string name, int d, int eo, bit et, bit ev);
        chk({name, ".out"}, int'(o[d]), eo);
        chk({name, ".tc"},  int'(tcs[d]), int'(et));
        chk({name, ".ovf"}, int'(ovfs[d]), int'(ev));
    endtask

    task automatic idle_inputs();
        en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0; dir = 1'b1; sat = 1'b0;
    endtask

    task automatic do_reset(int d);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk_dut($sformatf("reset_d%0d", d), d, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step_check(string name, int d, bit c, bit l, logic [3:0] lv,
                              bit di, bit s, bit e, int eo, bit et, bit ev);
        @(negedge clk);
        clr = c; load = l; load_val = lv; dir = di; sat = s; en = e;
        @(posedge clk);
        #1;
        chk_dut(name, d, eo, et, ev);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle_inputs();

        // MODULUS=10: down wrap, clamp, saturate, priority
        vt.push_back(mk(1,1,0,1, 2,0,0,0, 2,0,0));
        vt.push_back(mk(1,0,0,0, 0,0,0,1, 1,0,0));
        vt.push_back(mk(1,0,0,0, 0,0,0,1, 0,0,0));
        vt.push_back(mk(1,0,0,0, 0,0,0,1, 9,1,1));
        vt.push_back(mk(1,0,0,0, 0,0,0,1, 8,0,1));
        vt.push_back(mk(1,0,0,0, 0,0,0,0, 8,0,1));
        vt.push_back(mk(1,0,0,1,13,0,0,0, 9,0,1));
        vt.push_back(mk(1,0,1,0, 0,0,0,0, 0,0,0));
        vt.push_back(mk(1,0,0,1, 8,1,1,0, 8,0,0));
        vt.push_back(mk(1,0,0,0, 0,1,1,1, 9,0,0));
        vt.push_back(mk(1,0,0,0, 0,1,1,1, 9,1,1));
        vt.push_back(mk(1,0,0,0, 0,1,1,1, 9,1,1));
        vt.push_back(mk(1,0,0,0, 0,1,1,1, 9,1,1));
        vt.push_back(mk(1,0,0,0, 0,0,1,1, 8,0,1));
        vt.push_back(mk(1,0,0,0, 0,0,1,1, 7,0,1));
        vt.push_back(mk(1,0,0,1, 7,0,0,0, 7,0,1));
        vt.push_back(mk(1,0,1,1, 3,1,0,1, 0,0,0));
        vt.push_back(mk(1,0,0,1, 5,1,0,1, 5,0,0));
        vt.push_back(mk(1,0,0,0, 0,1,0,1, 6,0,0));
        vt.push_back(mk(1,0,0,1, 9,1,0,0, 9,0,0));
        vt.push_back(mk(1,0,0,0, 0,1,0,1, 0,1,1));
        vt.push_back(mk(1,0,0,0, 0,1,0,0, 0,0,1));
        // PRESCALE=3: period, en stretch, load restarts phase
        vt.push_back(mk(2,1,0,0, 0,1,0,1, 0,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 0,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 1,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 1,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 1,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 2,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 2,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,0, 2,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,0, 2,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 2,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 3,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1, 3,0,0));
        vt.push_back(mk(2,0,0,1,10,1,0,1,10,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1,10,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1,10,0,0));
        vt.push_back(mk(2,0,0,0, 0,1,0,1,11,0,0));

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset(vt[i].dut);
            step_check($sformatf("vec%0d", i), vt[i].dut, vt[i].clr, vt[i].load, vt[i].lv,
                       vt[i].dir, vt[i].sat, vt[i].en, vt[i].eo, vt[i].etc, vt[i].eovf);
        end

        // Defaults: 20 enabled up-count edges, wrap at 15
        do_reset(0);
        for (int k = 1; k <= 20; k++) begin
            step_check($sformatf("up%0d", k), 0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1,
                       k % 16, (k == 16), (k >= 16));
        end

        // MODULUS=7, PRESCALE=3: wrap down to 6 with tc, then async reset between edges
        do_reset(3);
        step_check("m7_a", 3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step_check("m7_b", 3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step_check("m7_c", 3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 6, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_dut("async_rst", 3, 0, 1'b0, 1'b0);
        dir = 1'b1;
        #1;
        rst_n = 1'b1;
        step_check("post_rst_a", 3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step_check("post_rst_b", 3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step_check("post_rst_c", 3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
